e1_tx_hdb3: RTL and testbench

- Line-coding stage placed directly downstream of the E1 transmit framer.
- Consumes the framer's serial NRZ bit stream (one bit per valid strobe) and produces HDB3-coded or AMI-coded bipolar return-to-zero pulses on two unipolar lines (pos/neg) for the LIU / output driver.
- Pulse width is set in clock cycles.
- Provides loss-free polarity/violation bookkeeping across the whole stream.

---
 rtl/e1_tx_hdb3.sv | 187 ++++++++++++++++++
 tb/tb_e1_tx_hdb3.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/e1_tx_hdb3.sv
// -----------------------------------------------------------------------------
// e1_tx_hdb3
//
// Transmit line coder for E1. Takes the framer's serial NRZ stream (one bit per
// in_valid strobe) and produces HDB3- or AMI-coded bipolar return-to-zero
// pulses on two unipolar lines for the line interface.
//
// A 4-slot symbol delay line gives the encoder enough lookahead to replace the
// first zero of a four-zero run with a B pulse once the fourth zero is known.
// Each strobe shifts the line by one slot. The symbol that leaves the oldest
// slot is turned into a pulse in the following cycle.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   in_bit       NRZ data bit, 1 = mark
//   in_valid     single-cycle strobe qualifying in_bit
//   ctrl_hdb3    1 = HDB3 substitution, 0 = plain AMI (sampled per strobe)
//   ctrl_invert  1 = swap the pos/neg lines (sampled per strobe)
//   out_pos      positive pulse line, active high
//   out_neg      negative pulse line, active high
//   out_stb      one-cycle strobe at the start of every output symbol slot
//   stat_bpv     one-cycle strobe when the slot carries a V (bipolar violation)
//
// Parameter:
//   PULSE_W      RZ pulse length in clk cycles, 1..15. Must be shorter than
//                the minimum spacing between in_valid strobes.
// -----------------------------------------------------------------------------
module e1_tx_hdb3 #(
    parameter int unsigned PULSE_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_bit,
    input  logic in_valid,
    input  logic ctrl_hdb3,
    input  logic ctrl_invert,
    output logic out_pos,
    output logic out_neg,
    output logic out_stb,
    output logic stat_bpv
);

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_ONE  = 2'b01,
        SYM_B    = 2'b10,
        SYM_V    = 2'b11
    } sym_t;

    // The pulse counter holds the cycles that remain after the current one.
    localparam logic [3:0] PCNT_LOAD = 4'(PULSE_W - 1);

    // Delay line: index 0 holds the newest symbol and index 3 the oldest.
    sym_t       dly_q [4];
    sym_t       dly_d [4];
    logic [1:0] zcnt_q, zcnt_d;           // consecutive zeros seen (0..3)
    logic       parity_q, parity_d;       // marks since the last V, modulo 2
    logic       last_pol_q, last_pol_d;   // polarity of the last pulse, 1 = positive
    logic [3:0] pcnt_q, pcnt_d;
    logic       pos_q, pos_d;
    logic       neg_q, neg_d;
    logic       stb_q, stb_d;
    logic       bpv_q, bpv_d;

    sym_t       emit_sym;
    logic       emit_mark;
    logic       emit_pol;
    logic       line_pos;

    // ---------------------------------------------------------------------
    // Input side: shift the delay line and apply HDB3 substitution.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold value first, so no path through
        // this block leaves one unassigned, and no latch is inferred.
        dly_d    = dly_q;
        zcnt_d   = zcnt_q;
        parity_d = parity_q;

        if (in_valid) begin
            dly_d[3] = dly_q[2];
            dly_d[2] = dly_q[1];
            dly_d[1] = dly_q[0];

            if (in_bit) begin
                dly_d[0] = SYM_ONE;
                zcnt_d   = 2'd0;
                parity_d = ~parity_q;
            end else if (!ctrl_hdb3 || (zcnt_q != 2'd3)) begin
                dly_d[0] = SYM_ZERO;
                // In AMI the count saturates. A switch to HDB3 after a long
                // run therefore substitutes on the next zero.
                if (zcnt_q != 2'd3) begin
                    zcnt_d = zcnt_q + 2'd1;
                end
            end else begin
                // This is the fourth zero in a row. After the shift, the first
                // zero of the run sits in slot 3. That zero becomes B when an
                // even number of marks since the last V would otherwise give
                // two V pulses of the same polarity in a row.
                dly_d[0] = SYM_V;
                if (!parity_q) begin
                    dly_d[3] = SYM_B;
                end
                zcnt_d   = 2'd0;
                parity_d = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output side: polarity bookkeeping and RZ pulse shaping.
    // ---------------------------------------------------------------------
    always_comb begin
        emit_sym  = dly_q[3];
        emit_mark = (emit_sym != SYM_ZERO);
        // A V repeats the previous polarity. ONE and B alternate the polarity.
        emit_pol  = (emit_sym == SYM_V) ? last_pol_q : ~last_pol_q;
        line_pos  = emit_pol ^ ctrl_invert;

        last_pol_d = last_pol_q;
        pcnt_d     = pcnt_q;
        pos_d      = pos_q;
        neg_d      = neg_q;
        stb_d      = in_valid;
        bpv_d      = in_valid && (emit_sym == SYM_V);

        if (in_valid) begin
            // A new slot replaces any pulse still in progress. Both lines are
            // loaded together from complementary terms, so they can never be
            // high at the same time, even on a restart.
            if (emit_mark) begin
                last_pol_d = emit_pol;
            end
            pos_d  = emit_mark && line_pos;
            neg_d  = emit_mark && !line_pos;
            pcnt_d = emit_mark ? PCNT_LOAD : 4'd0;
        end else if (pcnt_q != 4'd0) begin
            pcnt_d = pcnt_q - 4'd1;
        end else begin
            pos_d = 1'b0;
            neg_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: the delay line is reset like any other register. It holds encoder
    // state, not buffered data, so stale symbols after reset would emit
    // spurious pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                dly_q[i] <= SYM_ZERO;
            end
            zcnt_q     <= 2'd0;
            parity_q   <= 1'b0;
            last_pol_q <= 1'b0;
            pcnt_q     <= 4'd0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
            stb_q      <= 1'b0;
            bpv_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register in this block
            // take its value from the pre-edge state, whatever the statement
            // order.
            dly_q      <= dly_d;
            zcnt_q     <= zcnt_d;
            parity_q   <= parity_d;
            last_pol_q <= last_pol_d;
            pcnt_q     <= pcnt_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            stb_q      <= stb_d;
            bpv_q      <= bpv_d;
        end
    end

    assign out_pos  = pos_q;
    assign out_neg  = neg_q;
    assign out_stb  = stb_q;
    assign stat_bpv = bpv_q;

endmodule

// File: tb/tb_e1_tx_hdb3.sv
// -----------------------------------------------------------------------------
// tb_e1_tx_hdb3
//
// Self-checking bench for e1_tx_hdb3.
//  - Directed sequences are held as a table of {input, expected line} records.
//  - Short hand-written sequences cover reset during a pulse, reset between
//    strobes, and a strobe that arrives while a pulse is still active.
//  - A randomized run is compared with a stream-level HDB3/AMI model. The model
//    keeps the whole symbol history and applies the substitution rules to it.
// Each symbol slot is checked on every clock cycle: pos, neg, stb and bpv.
// -----------------------------------------------------------------------------
module tb_e1_tx_hdb3;

    localparam int PW = 6;

    logic clk;
    logic rst_n;
    logic in_bit;
    logic in_valid;
    logic ctrl_hdb3;
    logic ctrl_invert;
    logic out_pos;
    logic out_neg;
    logic out_stb;
    logic stat_bpv;

    int checks = 0;
    int errors = 0;

    e1_tx_hdb3 #(.PULSE_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .ctrl_hdb3   (ctrl_hdb3),
        .ctrl_invert (ctrl_invert),
        .out_pos     (out_pos),
        .out_neg     (out_neg),
        .out_stb     (out_stb),
        .stat_bpv    (stat_bpv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Check helper
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {pos,neg,stb,bpv} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs();
        return {out_pos, out_neg, out_stb, stat_bpv};
    endfunction

    // ------------------------------------------------------------------
    // Reference model. It works on the whole symbol stream: the coded symbol
    // for strobe k goes on the line at strobe k+4.
    // ------------------------------------------------------------------
    typedef enum int {M_ZERO, M_ONE, M_B, M_V} msym_e;
    msym_e syms[$];
    logic  m_last_pol;

    task automatic model_clear();
        syms.delete();
        m_last_pol = 1'b0;
    endtask

    task automatic model_push(input logic b, input logic hdb3, input logic inv,
                              output logic ep, output logic en, output logic ev);
        int    n;
        int    run;
        int    ones;
        int    k;
        msym_e e;
        logic  pol;
        logic  mark;
        n    = syms.size();
        run  = 0;
        ones = 0;
        for (int i = n - 1; i >= 0 && syms[i] == M_ZERO; i--) run++;
        if (b) begin
            syms.push_back(M_ONE);
        end else if (hdb3 && run >= 3) begin
            for (int i = n - 1; i >= 0 && syms[i] != M_V; i--)
                if (syms[i] == M_ONE) ones++;
            if (ones % 2 == 0) syms[n-3] = M_B;
            syms.push_back(M_V);
        end else begin
            syms.push_back(M_ZERO);
        end
        k    = syms.size() - 1;
        e    = (k >= 4) ? syms[k-4] : M_ZERO;
        mark = (e != M_ZERO);
        pol  = (e == M_V) ? m_last_pol : ~m_last_pol;
        if (mark) m_last_pol = pol;
        ep = mark && (pol ^ inv);
        en = mark && !(pol ^ inv);
        ev = (e == M_V);
    endtask

    // ------------------------------------------------------------------
    // Stimulus primitives. Both tasks are entered and left on a negedge.
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        #1;
        check("reset_outputs", outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        check("post_reset_idle", outs(), 4'b0000);
    endtask

    // One strobe, then span cycles of checks. The expected pulse line is high
    // for the first PW cycles, and stb/bpv are high in the first cycle only.
    task automatic send(input string tag, input logic b, input logic hdb3, input logic inv,
                        input logic ep, input logic en, input logic ev, input int span);
        logic [3:0] exp;
        in_bit      = b;
        ctrl_hdb3   = hdb3;
        ctrl_invert = inv;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < span; c++) begin
            exp = {ep && (c < PW), en && (c < PW), c == 0, ev && (c == 0)};
            check(tag, outs(), exp);
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        string tag;
        bit    rst;
        logic  b;
        logic  hdb3;
        logic  inv;
        logic  ep;
        logic  en;
        logic  ev;
    } vec_t;

    vec_t vecs[$];

    // exps: '0' empty slot, '+'/'-' mark on pos/neg, 'P'/'N' V on pos/neg.
    task automatic add_seq(input string tag, input string bits, input string exps,
                           input logic hdb3, input logic inv);
        for (int i = 0; i < bits.len(); i++) begin
            vec_t v;
            byte  ch;
            ch     = exps.getc(i);
            v.tag  = $sformatf("%s[%0d]", tag, i);
            v.rst  = (i == 0);
            v.b    = (bits.getc(i) == "1");
            v.hdb3 = hdb3;
            v.inv  = inv;
            v.ep   = (ch == "+") || (ch == "P");
            v.en   = (ch == "-") || (ch == "N");
            v.ev   = (ch == "P") || (ch == "N");
            vecs.push_back(v);
        end
    endtask

    initial begin
        logic ep;
        logic en;
        logic ev;
        logic b;
        logic hdb3;
        logic inv;

        rst_n       = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        ctrl_hdb3   = 1'b1;
        ctrl_invert = 1'b0;
        model_clear();

        add_seq("ones8",       "111111110000",     "0000+-+-+-+-",     1'b1, 1'b0);
        add_seq("odd_v",       "100001111",        "0000+000P",        1'b1, 1'b0);
        add_seq("even_bv",     "11000011111",      "0000+-+00P-",      1'b1, 1'b0);
        add_seq("zeros12",     "0000000000001111", "0000+00P-00N+00P", 1'b1, 1'b0);
        add_seq("ami",         "0000000010000",    "000000000000+",    1'b0, 1'b0);
        add_seq("ami_inv",     "0000000010000",    "000000000000-",    1'b0, 1'b1);
        add_seq("hdb3_inv",    "100001111",        "0000-000N",        1'b1, 1'b1);

        @(negedge clk);
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            send(vecs[i].tag, vecs[i].b, vecs[i].hdb3, vecs[i].inv,
                 vecs[i].ep, vecs[i].en, vecs[i].ev, PW + 1);
        end

        // --- Reset during an active pulse ---
        do_reset();
        for (int i = 0; i < 4; i++) send("rst_mid_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PW + 1);
        send("rst_mid_pulse", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_drop", outs(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        // After release: 4 empty slots, then the first mark is positive.
        for (int i = 0; i < 4; i++) send("rst_mid_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PW + 1);
        send("rst_mid_first", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PW + 1);

        // --- Reset between strobes after a positive mark (last_pol = 1) ---
        send("rst_idle_m", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, PW + 1);
        send("rst_idle_p", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PW + 1);
        do_reset();
        for (int i = 0; i < 4; i++) send("rst_idle_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PW + 1);
        send("rst_idle_first", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PW + 1);

        // --- Strobe arriving mid-pulse: old pulse cut, new one starts ---
        do_reset();
        for (int i = 0; i < 4; i++) send("overlap_fill", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, PW + 1);
        send("overlap_first", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        send("overlap_second", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, PW + 1);

        // --- Randomized run against the stream model ---
        do_reset();
        hdb3 = 1'b1;
        inv  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            b = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) hdb3 = ~hdb3;
            if ($urandom_range(0, 7) == 0)  inv  = ~inv;
            model_push(b, hdb3, inv, ep, en, ev);
            send("random", b, hdb3, inv, ep, en, ev, $urandom_range(PW + 1, PW + 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
